rgb_mem_arbiter: RTL and testbench

Sequencer and arbiter for the shared single-port RGB pixel memory (three planes, selected by the RGB code from the control unit). It serves two requesters:
- CPU load/store to one colour plane.
- Video scan-out read that fetches all three planes of one pixel.
It serializes memory accesses, tracks read latency, stalls the CPU while its access is pending, and gives fair alternation when both requesters are pending.

---
 rtl/rgb_mem_pkg.sv | 28 ++
 rtl/rgb_mem_arbiter_if.sv | 40 ++++
 rtl/rgb_read_capture.sv | 75 +++++++
 rtl/rgb_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_rgb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_mem_pkg.sv
// Shared types and constants for the RGB pixel memory arbiter.
package rgb_mem_pkg;

   localparam logic [1:0] PLANE_R    = 2'b00;
   localparam logic [1:0] PLANE_G    = 2'b01;
   localparam logic [1:0] PLANE_B    = 2'b10;
   localparam logic [1:0] PLANE_NONE = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StCpuAcc,
      StCpuWait,
      StVidIssue,
      StVidDrain
   } state_t;

   typedef enum logic {
      GRANT_CPU,
      GRANT_VID
   } grant_t;

   typedef struct packed {
      logic       valid;
      grant_t     dest;
      logic [1:0] plane;
   } tag_t;

endpackage

// File: rtl/rgb_mem_arbiter_if.sv
// Bus bundle between the RGB memory arbiter, its two requesters and the pixel memory.
interface rgb_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
);
   logic                cpu_req;
   logic                cpu_we;
   logic [1:0]          cpu_rgb;
   logic [ADDR_W-1:0]   cpu_addr;
   logic [DATA_W-1:0]   cpu_wdata;
   logic [DATA_W-1:0]   cpu_rdata;
   logic                cpu_done;
   logic                cpu_err;
   logic                cpu_stall;
   logic                vid_req;
   logic [ADDR_W-1:0]   vid_addr;
   logic [3*DATA_W-1:0] vid_rdata;
   logic                vid_valid;
   logic                mem_en;
   logic                mem_we;
   logic [1:0]          mem_plane;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;

   // Requesters and memory side
   modport master (
      output cpu_req, cpu_we, cpu_rgb, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
      input  cpu_rdata, cpu_done, cpu_err, cpu_stall, vid_rdata, vid_valid,
      input  mem_en, mem_we, mem_plane, mem_addr, mem_wdata
   );

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_rgb, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
      output cpu_rdata, cpu_done, cpu_err, cpu_stall, vid_rdata, vid_valid,
      output mem_en, mem_we, mem_plane, mem_addr, mem_wdata
   );

endinterface

// File: rtl/rgb_read_capture.sv
// Read-latency tag pipeline and result capture registers for CPU loads and video pixel fetches.
module rgb_read_capture
   import rgb_mem_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  tag_t                i_tag,
   input  logic [DATA_W-1:0]   i_mem_rdata,
   input  logic                i_cpu_clr,
   output logic                o_cpu_cap,
   output logic                o_vid_cap,
   output logic [DATA_W-1:0]   o_cpu_rdata,
   output logic [3*DATA_W-1:0] o_vid_rdata,
   output logic                o_vid_valid
);
   tag_t                r_tag [MEM_LAT];
   tag_t                w_tag_out;
   logic [DATA_W-1:0]   r_red;
   logic [DATA_W-1:0]   r_green;
   logic [DATA_W-1:0]   r_cpu_rdata;
   logic [3*DATA_W-1:0] r_vid_rdata;
   logic                r_vid_valid;
   logic                w_vid_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= i_tag;
         for (int i = 1; i < MEM_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   // Tag at the tail lines up with the cycle its data is on mem_rdata.
   always_comb begin
      w_tag_out = r_tag[MEM_LAT-1];
      w_vid_hit = w_tag_out.valid && (w_tag_out.dest == GRANT_VID);
      o_cpu_cap = w_tag_out.valid && (w_tag_out.dest == GRANT_CPU);
      o_vid_cap = w_vid_hit && (w_tag_out.plane == PLANE_B);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_red       <= '0;
         r_green     <= '0;
         r_cpu_rdata <= '0;
         r_vid_rdata <= '0;
         r_vid_valid <= 1'b0;
      end else begin
         r_vid_valid <= o_vid_cap;
         if (i_cpu_clr) begin
            r_cpu_rdata <= '0;
         end else if (o_cpu_cap) begin
            r_cpu_rdata <= i_mem_rdata;
         end
         // R and G are staged so the visible pixel word changes only with vid_valid
         if (w_vid_hit) begin
            case (w_tag_out.plane)
               PLANE_R: r_red       <= i_mem_rdata;
               PLANE_G: r_green     <= i_mem_rdata;
               PLANE_B: r_vid_rdata <= {r_red, r_green, i_mem_rdata};
               default: ;
            endcase
         end
      end
   end

   assign o_cpu_rdata = r_cpu_rdata;
   assign o_vid_rdata = r_vid_rdata;
   assign o_vid_valid = r_vid_valid;

endmodule

// File: rtl/rgb_mem_arbiter.sv
// Serialises CPU plane accesses and three-plane video pixel fetches onto one single-port memory,
// alternating fairly when both requesters are pending.
module rgb_mem_arbiter
   import rgb_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned MEM_LAT = 2
) (
   input logic              clk,
   input logic              rst,
   rgb_mem_arbiter_if.slave bus
);
   state_t            r_state;
   grant_t            r_last_grant;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [1:0]        r_mem_plane;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_cpu_done;
   logic              r_cpu_err;
   logic              w_grant_cpu;
   logic              w_grant_vid;
   logic              w_cpu_illegal;
   logic              w_cpu_cap;
   logic              w_vid_cap;
   tag_t              w_tag;

   always_comb begin
      w_grant_cpu   = (r_state == StIdle) && bus.cpu_req &&
                      (!bus.vid_req || (r_last_grant == GRANT_VID));
      w_grant_vid   = (r_state == StIdle) && bus.vid_req && !w_grant_cpu;
      w_cpu_illegal = w_grant_cpu && (bus.cpu_rgb == PLANE_NONE);
   end

   always_comb begin
      w_tag       = '0;
      w_tag.valid = r_mem_en && !r_mem_we;
      w_tag.dest  = (r_state == StVidIssue) ? GRANT_VID : GRANT_CPU;
      w_tag.plane = r_mem_plane;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         r_last_grant <= GRANT_CPU;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_plane  <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_cpu_done   <= 1'b0;
         r_cpu_err    <= 1'b0;
      end else begin
         r_cpu_done <= 1'b0;
         r_cpu_err  <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_grant_cpu) begin
                  r_last_grant <= GRANT_CPU;
                  if (w_cpu_illegal) begin
                     r_cpu_done <= 1'b1;
                     r_cpu_err  <= 1'b1;
                  end else begin
                     r_state     <= StCpuAcc;
                     r_mem_en    <= 1'b1;
                     r_mem_we    <= bus.cpu_we;
                     r_mem_plane <= bus.cpu_rgb;
                     r_mem_addr  <= bus.cpu_addr;
                     r_mem_wdata <= bus.cpu_we ? bus.cpu_wdata : '0;
                  end
               end else if (w_grant_vid) begin
                  r_last_grant <= GRANT_VID;
                  r_state      <= StVidIssue;
                  r_mem_en     <= 1'b1;
                  r_mem_we     <= 1'b0;
                  r_mem_plane  <= PLANE_R;
                  r_mem_addr   <= bus.vid_addr;
                  r_mem_wdata  <= '0;
               end
            end
            StCpuAcc: begin
               r_mem_en    <= 1'b0;
               r_mem_we    <= 1'b0;
               r_mem_plane <= '0;
               r_mem_addr  <= '0;
               r_mem_wdata <= '0;
               if (r_mem_we) begin
                  r_state    <= StIdle;
                  r_cpu_done <= 1'b1;
               end else begin
                  r_state <= StCpuWait;
               end
            end
            StCpuWait: begin
               if (w_cpu_cap) begin
                  r_state    <= StIdle;
                  r_cpu_done <= 1'b1;
               end
            end
            StVidIssue: begin
               // mem_addr holds the latched pixel address across all three plane strobes
               if (r_mem_plane == PLANE_B) begin
                  r_state     <= StVidDrain;
                  r_mem_en    <= 1'b0;
                  r_mem_plane <= '0;
                  r_mem_addr  <= '0;
               end else begin
                  r_mem_plane <= r_mem_plane + 2'd1;
               end
            end
            StVidDrain: begin
               if (w_vid_cap) r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   rgb_read_capture #(
      .DATA_W  (DATA_W),
      .MEM_LAT (MEM_LAT)
   ) u_capture (
      .clk         (clk),
      .rst         (rst),
      .i_tag       (w_tag),
      .i_mem_rdata (bus.mem_rdata),
      .i_cpu_clr   (w_cpu_illegal),
      .o_cpu_cap   (w_cpu_cap),
      .o_vid_cap   (w_vid_cap),
      .o_cpu_rdata (bus.cpu_rdata),
      .o_vid_rdata (bus.vid_rdata),
      .o_vid_valid (bus.vid_valid)
   );

   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_plane = r_mem_plane;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.cpu_done  = r_cpu_done;
   assign bus.cpu_err   = r_cpu_err;
   assign bus.cpu_stall = bus.cpu_req && !r_cpu_done && !rst;

endmodule

// File: tb/tb_rgb_mem_arbiter.sv
// Scoreboard bench for rgb_mem_arbiter: directed transactions push expected strobes and
// completions; a negedge monitor pops and compares whatever the DUT presents.
module tb_rgb_mem_arbiter;
   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned MEM_LAT = 2;

   typedef struct {
      int          cyc;
      logic        we;
      logic [1:0]  plane;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } strobe_t;

   typedef struct {
      int         cyc;
      logic       err;
      logic [7:0] rdata;
   } cpu_t;

   typedef struct {
      int          cyc;
      logic [23:0] rdata;
   } vid_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   strobe_t q_str[$];
   cpu_t    q_cpu[$];
   vid_t    q_vid[$];

   logic [7:0] mem [3][1024];
   logic [7:0] rd_dly [MEM_LAT];

   rgb_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   rgb_mem_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MEM_LAT (MEM_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc <= cyc + 1;
   end

   // Memory model: writes land at the strobe edge, read data appears MEM_LAT cycles after strobe
   assign bus.mem_rdata = rd_dly[MEM_LAT-1];
   initial forever begin
      @(posedge clk);
      if (rst) begin
         mem[0][10'h200] <= 8'h11;
         mem[1][10'h200] <= 8'h22;
         mem[2][10'h200] <= 8'h33;
         mem[0][10'h201] <= 8'h44;
         mem[1][10'h201] <= 8'h55;
         mem[2][10'h201] <= 8'h66;
         mem[2][10'h010] <= 8'h3C;
      end else if (bus.mem_en && bus.mem_we && bus.mem_plane != 2'b11) begin
         mem[bus.mem_plane][bus.mem_addr[9:0]] <= bus.mem_wdata;
      end
      if (bus.mem_en && !bus.mem_we && bus.mem_plane != 2'b11)
         rd_dly[0] <= mem[bus.mem_plane][bus.mem_addr[9:0]];
      else
         rd_dly[0] <= 8'h00;
      for (int i = 1; i < MEM_LAT; i++) rd_dly[i] <= rd_dly[i-1];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return {bus.cpu_rdata, bus.cpu_done, bus.cpu_err, bus.cpu_stall, bus.vid_rdata,
              bus.vid_valid, bus.mem_en, bus.mem_we, bus.mem_plane, bus.mem_addr, bus.mem_wdata};
   endfunction

   // Monitor
   initial begin : mon
      strobe_t s;
      cpu_t    c;
      vid_t    v;
      forever begin
         @(negedge clk);
         if (bus.mem_en) begin
            if (q_str.size() == 0) begin
               check("unexpected_strobe", 64'(cyc), 64'hFFFF);
            end else begin
               s = q_str.pop_front();
               check("strobe", {16'(cyc), bus.mem_we, bus.mem_plane, bus.mem_addr, bus.mem_wdata},
                     {16'(s.cyc), s.we, s.plane, s.addr, s.wdata});
            end
         end
         if (bus.cpu_done) begin
            if (q_cpu.size() == 0) begin
               check("unexpected_cpu_done", 64'(cyc), 64'hFFFF);
            end else begin
               c = q_cpu.pop_front();
               check("cpu_done", {16'(cyc), bus.cpu_err, bus.cpu_rdata},
                     {16'(c.cyc), c.err, c.rdata});
            end
         end
         if (bus.vid_valid) begin
            if (q_vid.size() == 0) begin
               check("unexpected_vid_valid", 64'(cyc), 64'hFFFF);
            end else begin
               v = q_vid.pop_front();
               check("vid_valid", {16'(cyc), bus.vid_rdata}, {16'(v.cyc), v.rdata});
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) next_cycle();
   endtask

   task automatic push_vid_strobes(input int b, input logic [15:0] addr);
      for (int p = 0; p < 3; p++) q_str.push_back('{b + 1 + p, 1'b0, 2'(p), addr, 8'h00});
   endtask

   initial begin : stim
      int b;
      int m;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_rgb   = 2'b00;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.vid_req   = 1'b0;
      bus.vid_addr  = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", all_outputs(), 64'h0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("idle_outputs", all_outputs(), 64'h0);

      // 1: store G plane
      wait_until(cyc + 2);
      b = cyc;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_rgb = 2'b01;
      bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'hA5;
      q_str.push_back('{b + 1, 1'b1, 2'b01, 16'h0010, 8'hA5});
      q_cpu.push_back('{b + 2, 1'b0, 8'h00});
      @(negedge clk);
      check("t1_stall_c0", 64'(bus.cpu_stall), 64'h1);
      @(negedge clk);
      check("t1_stall_c1", 64'(bus.cpu_stall), 64'h1);
      wait_until(b + 2);
      bus.cpu_req = 1'b0;
      wait_until(b + 4);

      // 2: load B plane
      b = cyc;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_rgb = 2'b10;
      bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'h00;
      q_str.push_back('{b + 1, 1'b0, 2'b10, 16'h0010, 8'h00});
      q_cpu.push_back('{b + 4, 1'b0, 8'h3C});
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("t2_stall_c2", 64'(bus.cpu_stall), 64'h1);
      wait_until(b + 4);
      bus.cpu_req = 1'b0;
      wait_until(b + 7);
      check("t2_rdata_held", 64'(bus.cpu_rdata), 64'h3C);

      // 3: video fetch
      b = cyc;
      bus.vid_req = 1'b1; bus.vid_addr = 16'h0200;
      push_vid_strobes(b, 16'h0200);
      q_vid.push_back('{b + 6, 24'h112233});
      next_cycle();
      bus.vid_req = 1'b0;
      wait_until(b + 8);
      check("t3_vid_rdata_held", 64'(bus.vid_rdata), 64'h112233);
      check("t3_cpu_rdata_kept", 64'(bus.cpu_rdata), 64'h3C);

      // 5: illegal plane code
      b = cyc;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_rgb = 2'b11;
      bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'hFF;
      q_cpu.push_back('{b + 1, 1'b1, 8'h00});
      next_cycle();
      bus.cpu_req = 1'b0;
      wait_until(b + 4);

      // 6: reset in cycle 2 of a video fetch, then a store after release
      b = cyc;
      bus.vid_req = 1'b1; bus.vid_addr = 16'h0200;
      q_str.push_back('{b + 1, 1'b0, 2'b00, 16'h0200, 8'h00});
      next_cycle();
      bus.vid_req = 1'b0;
      next_cycle();
      rst = 1'b1;
      #1;
      check("t6_reset_outputs", all_outputs(), 64'h0);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_rgb = 2'b01;
      bus.cpu_addr = 16'h0030; bus.cpu_wdata = 8'h5C;
      @(negedge clk);
      check("t6_stall_in_reset", 64'(bus.cpu_stall), 64'h0);
      wait_until(b + 4);
      rst = 1'b0;
      m = cyc;
      q_str.push_back('{m + 1, 1'b1, 2'b01, 16'h0030, 8'h5C});
      q_cpu.push_back('{m + 2, 1'b0, 8'h00});
      @(negedge clk);
      check("t6_stall_after_release", 64'(bus.cpu_stall), 64'h1);
      wait_until(m + 2);
      bus.cpu_req = 1'b0;
      wait_until(m + 10);

      // 4: both requesters held from reset -> V, C, V, C
      rst = 1'b1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_rgb = 2'b00;
      bus.cpu_addr = 16'h0020; bus.cpu_wdata = 8'h5A;
      bus.vid_req = 1'b1; bus.vid_addr = 16'h0201;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      b = cyc;
      push_vid_strobes(b, 16'h0201);
      q_vid.push_back('{b + 6, 24'h445566});
      q_str.push_back('{b + 7, 1'b1, 2'b00, 16'h0020, 8'h5A});
      q_cpu.push_back('{b + 8, 1'b0, 8'h00});
      push_vid_strobes(b + 8, 16'h0201);
      q_vid.push_back('{b + 14, 24'h445566});
      q_str.push_back('{b + 15, 1'b1, 2'b00, 16'h0020, 8'h5A});
      q_cpu.push_back('{b + 16, 1'b0, 8'h00});
      wait_until(b + 16);
      bus.cpu_req = 1'b0;
      bus.vid_req = 1'b0;
      wait_until(b + 24);

      check("strobes_outstanding", 64'(q_str.size()), 64'h0);
      check("cpu_done_outstanding", 64'(q_cpu.size()), 64'h0);
      check("vid_valid_outstanding", 64'(q_vid.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
